// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory wait count and IO req/ack timeout.
// Optional feature: define CTRL_UPPER_IMM_EN to decode LUI/AUIPC and expose upper_sel.
module multicycle_controller #(
    parameter int          MEM_LATENCY = 2,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FC00,
    parameter logic [31:0] IO_MASK     = 32'hFFFF_FC00,
    parameter int          IO_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_in,
    input  logic [31:0] alu_result,
    input  logic        branch_taken,
    input  logic        io_ack,
    output logic [31:0] ir,
    output logic        ir_write,
    output logic        pc_inc,
    output logic        pc_write_tgt,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_or_io_to_reg,
    output logic        sft,
    output logic        jump,
    output logic        branch,
    output logic [1:0]  alu_op,
    output logic [2:0]  branch_type,
    output logic        mem_read,
    output logic        mem_write,
    output logic        io_read,
    output logic        io_write,
    output logic        illegal_inst,
    output logic        bus_err,
`ifdef CTRL_UPPER_IMM_EN
    output logic [1:0]  upper_sel,
`endif
    output logic        busy
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [3:0] {K_R, K_I, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR,
                              K_LUI, K_AUIPC, K_ILL} kind_t;

    localparam logic [9:0] MEM_LAST = 10'(MEM_LATENCY - 1);
    localparam logic [9:0] IO_LAST  = 10'(IO_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        io_hit_q, io_hit_d;
    kind_t       kind;
    logic        is_load;

    logic        ir_write_c, pc_inc_c, pc_write_tgt_c, alu_src_c, reg_write_c;
    logic        mem_or_io_to_reg_c, sft_c, jump_c, branch_c;
    logic [1:0]  alu_op_c, upper_sel_c;
    logic [2:0]  branch_type_c;
    logic        mem_read_c, mem_write_c, io_read_c, io_write_c, illegal_c, bus_err_c;

    always_comb begin
        kind = K_ILL;
        case (ir_q[6:0])
            7'b0110011: kind = K_R;
            7'b0010011: kind = K_I;
            7'b0000011: kind = (ir_q[14:12] == 3'b010) ? K_LOAD : K_ILL;
            7'b0100011: kind = (ir_q[14:12] == 3'b010) ? K_STORE : K_ILL;
            7'b1100011: kind = K_BR;
            7'b1101111: kind = K_JAL;
            7'b1100111: kind = K_JALR;
`ifdef CTRL_UPPER_IMM_EN
            7'b0110111: kind = K_LUI;
            7'b0010111: kind = K_AUIPC;
`endif
            default:    kind = K_ILL;
        endcase
    end

    assign is_load = (kind == K_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            ir_q     <= '0;
            cnt_q    <= '0;
            io_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            io_hit_q <= io_hit_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        ir_d               = ir_q;
        cnt_d              = cnt_q;
        io_hit_d           = io_hit_q;
        ir_write_c         = 1'b0;
        pc_inc_c           = 1'b0;
        pc_write_tgt_c     = 1'b0;
        alu_src_c          = 1'b0;
        reg_write_c        = 1'b0;
        mem_or_io_to_reg_c = 1'b0;
        sft_c              = 1'b0;
        jump_c             = 1'b0;
        branch_c           = 1'b0;
        alu_op_c           = 2'b00;
        upper_sel_c        = 2'b00;
        branch_type_c      = 3'b000;
        mem_read_c         = 1'b0;
        mem_write_c        = 1'b0;
        io_read_c          = 1'b0;
        io_write_c         = 1'b0;
        illegal_c          = 1'b0;
        bus_err_c          = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_inc_c   = 1'b1;
                ir_d       = inst_in;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                illegal_c = (kind == K_ILL);
                state_d   = (kind == K_ILL) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                alu_src_c = (kind == K_I) || (kind == K_LOAD) || (kind == K_STORE) ||
                            (kind == K_JALR) || (kind == K_LUI) || (kind == K_AUIPC);
                alu_op_c  = (kind == K_R) ? 2'b10 : (kind == K_BR) ? 2'b01 : 2'b00;
                sft_c     = (kind == K_I) && (ir_q[13:12] == 2'b01);
                upper_sel_c = (kind == K_LUI) ? 2'b01 : (kind == K_AUIPC) ? 2'b10 : 2'b00;
                case (kind)
                    K_BR: begin
                        branch_c       = 1'b1;
                        branch_type_c  = ir_q[14:12];
                        pc_write_tgt_c = branch_taken;
                        state_d        = S_FETCH;
                    end
                    K_JAL, K_JALR: begin
                        jump_c         = 1'b1;
                        pc_write_tgt_c = 1'b1;
                        reg_write_c    = 1'b1;
                        state_d        = S_FETCH;
                    end
                    K_LOAD, K_STORE: begin
                        io_hit_d = ((alu_result & IO_MASK) == (IO_BASE & IO_MASK));
                        cnt_d    = '0;
                        state_d  = S_MEM;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (!io_hit_q) begin
                    mem_read_c  = is_load;
                    mem_write_c = !is_load;
                    if (cnt_q == MEM_LAST) begin
                        cnt_d   = '0;
                        state_d = is_load ? S_WB : S_FETCH;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end else if (cnt_q == IO_LAST) begin
                    // timeout cycle: strobe already dropped, abandon the access
                    bus_err_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_FETCH;
                end else begin
                    io_read_c  = is_load;
                    io_write_c = !is_load;
                    if (io_ack) begin
                        cnt_d   = '0;
                        state_d = is_load ? S_WB : S_FETCH;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            S_WB: begin
                reg_write_c        = 1'b1;
                mem_or_io_to_reg_c = is_load;
                state_d            = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Every output reads zero while reset is asserted.
    assign ir               = rst ? '0 : ir_q;
    assign ir_write         = ir_write_c & ~rst;
    assign pc_inc           = pc_inc_c & ~rst;
    assign pc_write_tgt     = pc_write_tgt_c & ~rst;
    assign alu_src          = alu_src_c & ~rst;
    assign reg_write        = reg_write_c & ~rst;
    assign mem_or_io_to_reg = mem_or_io_to_reg_c & ~rst;
    assign sft              = sft_c & ~rst;
    assign jump             = jump_c & ~rst;
    assign branch           = branch_c & ~rst;
    assign alu_op           = rst ? 2'b00 : alu_op_c;
    assign branch_type      = rst ? 3'b000 : branch_type_c;
    assign mem_read         = mem_read_c & ~rst;
    assign mem_write        = mem_write_c & ~rst;
    assign io_read          = io_read_c & ~rst;
    assign io_write         = io_write_c & ~rst;
    assign illegal_inst     = illegal_c & ~rst;
    assign bus_err          = bus_err_c & ~rst;
    assign busy             = (state_q != S_FETCH) & ~rst;
`ifdef CTRL_UPPER_IMM_EN
    assign upper_sel        = rst ? 2'b00 : upper_sel_c;
`else
    logic unused_upper;
    assign unused_upper = ^upper_sel_c;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction expected output traces from an instruction-level model.
module tb_multicycle_controller;

    localparam int          MEM_LAT = 2;
    localparam int          IO_TO   = 4;
    localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
    localparam logic [31:0] IO_MASK = 32'hFFFF_FC00;

    typedef struct packed {
        logic [31:0] ir;
        logic        ir_write, pc_inc, pc_write_tgt, alu_src, reg_write, mem_or_io_to_reg;
        logic        sft, jump, branch;
        logic [1:0]  alu_op;
        logic [2:0]  branch_type;
        logic        mem_read, mem_write, io_read, io_write, illegal_inst, bus_err, busy;
        logic [1:0]  upper_sel;
    } out_t;

    logic clk = 1'b0, rst, branch_taken, io_ack;
    logic [31:0] inst_in, alu_result;
    logic [31:0] ir;
    logic ir_write, pc_inc, pc_write_tgt, alu_src, reg_write, mem_or_io_to_reg, sft, jump, branch;
    logic [1:0] alu_op, upper_sel;
    logic [2:0] branch_type;
    logic mem_read, mem_write, io_read, io_write, illegal_inst, bus_err, busy;

    multicycle_controller #(.MEM_LATENCY(MEM_LAT), .IO_BASE(IO_BASE), .IO_MASK(IO_MASK),
                            .IO_TIMEOUT(IO_TO)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .alu_result(alu_result),
        .branch_taken(branch_taken), .io_ack(io_ack), .ir(ir), .ir_write(ir_write),
        .pc_inc(pc_inc), .pc_write_tgt(pc_write_tgt), .alu_src(alu_src), .reg_write(reg_write),
        .mem_or_io_to_reg(mem_or_io_to_reg), .sft(sft), .jump(jump), .branch(branch),
        .alu_op(alu_op), .branch_type(branch_type), .mem_read(mem_read), .mem_write(mem_write),
        .io_read(io_read), .io_write(io_write), .illegal_inst(illegal_inst), .bus_err(bus_err),
`ifdef CTRL_UPPER_IMM_EN
        .upper_sel(upper_sel),
`endif
        .busy(busy));

`ifndef CTRL_UPPER_IMM_EN
    assign upper_sel = 2'b00;
`endif

    always #5 clk = ~clk;

    out_t dut_o, exp_o;
    always_comb begin
        dut_o = '0;
        dut_o.ir = ir; dut_o.ir_write = ir_write; dut_o.pc_inc = pc_inc;
        dut_o.pc_write_tgt = pc_write_tgt; dut_o.alu_src = alu_src; dut_o.reg_write = reg_write;
        dut_o.mem_or_io_to_reg = mem_or_io_to_reg; dut_o.sft = sft; dut_o.jump = jump;
        dut_o.branch = branch; dut_o.alu_op = alu_op; dut_o.branch_type = branch_type;
        dut_o.mem_read = mem_read; dut_o.mem_write = mem_write; dut_o.io_read = io_read;
        dut_o.io_write = io_write; dut_o.illegal_inst = illegal_inst; dut_o.bus_err = bus_err;
        dut_o.busy = busy; dut_o.upper_sel = upper_sel;
    end

    int checks = 0, failures = 0;
    logic chk_en = 1'b0;
    string cur_tag = "reset";
    int cur_cyc = 0;
    int n_mrd = 0, n_mwr = 0, n_iord = 0, n_iowr = 0, n_rw = 0, n_berr = 0, n_ill = 0, n_tgt = 0;

    // Per-cycle comparison against the model's expected trace.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checks++;
            if (dut_o !== exp_o) begin
                failures++;
                $display("FAIL trace %s cycle %0d: got %h want %h", cur_tag, cur_cyc, dut_o, exp_o);
            end
        end
        n_mrd += int'(mem_read === 1'b1);   n_mwr += int'(mem_write === 1'b1);
        n_iord += int'(io_read === 1'b1);   n_iowr += int'(io_write === 1'b1);
        n_rw += int'(reg_write === 1'b1);   n_berr += int'(bus_err === 1'b1);
        n_ill += int'(illegal_inst === 1'b1); n_tgt += int'(pc_write_tgt === 1'b1);
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Instruction-level model: produces the expected outputs for each cycle of one instruction.
    out_t tl_q[$];
    logic ack_q[$];
    logic [31:0] cur_ir = '0;

    task automatic build(input logic [31:0] inst, input logic [31:0] addr, input logic taken,
                         input int ack_at, input logic pre_ack);
        out_t o;
        logic [6:0] opc;
        logic [2:0] f3;
        logic r, i, ld, st, br, jal, jalr, lui, aui, ill, io, ok;
        opc = inst[6:0];
        f3  = inst[14:12];
        tl_q.delete();
        ack_q.delete();
        r = opc == 7'h33; i = opc == 7'h13; br = opc == 7'h63; jal = opc == 7'h6F; jalr = opc == 7'h67;
        ld = (opc == 7'h03) && (f3 == 3'b010);
        st = (opc == 7'h23) && (f3 == 3'b010);
`ifdef CTRL_UPPER_IMM_EN
        lui = opc == 7'h37; aui = opc == 7'h17;
`else
        lui = 1'b0; aui = 1'b0;
`endif
        ill = !(r | i | ld | st | br | jal | jalr | lui | aui);
        o = '0; o.ir = cur_ir; o.ir_write = 1'b1; o.pc_inc = 1'b1;
        tl_q.push_back(o); ack_q.push_back(pre_ack);
        cur_ir = inst;
        o = '0; o.ir = inst; o.busy = 1'b1; o.illegal_inst = ill;
        tl_q.push_back(o); ack_q.push_back(pre_ack);
        if (ill) return;
        o = '0; o.ir = inst; o.busy = 1'b1;
        o.alu_src = i | ld | st | jalr | lui | aui;
        o.alu_op = r ? 2'b10 : br ? 2'b01 : 2'b00;
        o.sft = i && (f3 == 3'b001 || f3 == 3'b101);
        o.branch = br; o.branch_type = br ? f3 : 3'b000;
        o.pc_write_tgt = (br && taken) || jal || jalr;
        o.jump = jal | jalr; o.reg_write = jal | jalr;
        o.upper_sel = lui ? 2'b01 : aui ? 2'b10 : 2'b00;
        tl_q.push_back(o); ack_q.push_back(pre_ack);
        if (br | jal | jalr) return;
        ok = 1'b1;
        if (ld | st) begin
            io = (addr & IO_MASK) == (IO_BASE & IO_MASK);
            o = '0; o.ir = inst; o.busy = 1'b1;
            if (!io) begin
                o.mem_read = ld; o.mem_write = st;
                for (int k = 1; k <= MEM_LAT; k++) begin tl_q.push_back(o); ack_q.push_back(1'b0); end
            end else if (ack_at >= 1 && ack_at <= IO_TO) begin
                o.io_read = ld; o.io_write = st;
                for (int k = 1; k <= ack_at; k++) begin tl_q.push_back(o); ack_q.push_back(k == ack_at); end
            end else begin
                o.io_read = ld; o.io_write = st;
                for (int k = 1; k <= IO_TO; k++) begin tl_q.push_back(o); ack_q.push_back(1'b0); end
                o.io_read = 1'b0; o.io_write = 1'b0; o.bus_err = 1'b1;
                tl_q.push_back(o); ack_q.push_back(1'b0);
                ok = 1'b0;
            end
        end
        if (ok && !st) begin
            o = '0; o.ir = inst; o.busy = 1'b1; o.reg_write = 1'b1; o.mem_or_io_to_reg = ld;
            tl_q.push_back(o); ack_q.push_back(1'b0);
        end
    endtask

    task automatic apply(input out_t e, input logic ack);
        exp_o  = e;
        io_ack = ack;
        chk_en = 1'b1;
        @(posedge clk); #1;
        cur_cyc++;
    endtask

    // abort_at >= 0 asserts rst in that cycle of the trace instead of the modelled one.
    task automatic run(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                       input logic taken, input int ack_at, input logic pre_ack,
                       input int abort_at, output int n);
        build(inst, addr, taken, ack_at, pre_ack);
        n = tl_q.size();
        cur_tag = tag;
        cur_cyc = 0;
        alu_result = addr;
        branch_taken = taken;
        for (int c = 0; c < n; c++) begin
            inst_in = (c == 0) ? inst : 32'hDEAD_BEEF;
            if (c == abort_at) begin
                rst = 1'b1;
                apply('0, 1'b1);
                rst = 1'b0;
                cur_ir = '0;
                break;
            end
            apply(tl_q[c], ack_q[c]);
        end
    endtask

    int n, b_mrd, b_mwr, b_iord, b_iowr, b_rw, b_berr, b_ill, b_tgt;

    task automatic snap();
        b_mrd = n_mrd; b_mwr = n_mwr; b_iord = n_iord; b_iowr = n_iowr;
        b_rw = n_rw; b_berr = n_berr; b_ill = n_ill; b_tgt = n_tgt;
    endtask

    initial begin
        rst = 1'b1; inst_in = 32'h0000_0013; alu_result = '0; branch_taken = 1'b0; io_ack = 1'b1;
        apply('0, 1'b1);
        apply('0, 1'b1);
        rst = 1'b0;
        chk("reset ir", int'(ir), 0);
        chk("reset busy", int'(busy), 0);

        snap(); run("add", 32'h002081B3, 32'h0, 1'b0, 0, 1'b0, -1, n);
        chk("add cycles", n, 4);
        chk("add reg_write", n_rw - b_rw, 1);
        run("addi", 32'h00500093, 32'h0, 1'b0, 0, 1'b0, -1, n);
        run("slli", 32'h00209093, 32'h0, 1'b0, 0, 1'b0, -1, n);
        run("srai", 32'h4020D093, 32'h0, 1'b0, 0, 1'b0, -1, n);

        snap(); run("lw mem", 32'h00002283, 32'h0000_0010, 1'b0, 0, 1'b0, -1, n);
        chk("lw mem cycles", n, 6);
        chk("lw mem_read cycles", n_mrd - b_mrd, 2);
        chk("lw reg_write", n_rw - b_rw, 1);
        snap(); run("sw edge", 32'h00502023, 32'hFFFF_FBFC, 1'b0, 0, 1'b1, -1, n);
        chk("sw edge cycles", n, 5);
        chk("sw edge io_write", n_iowr - b_iowr, 0);

        snap(); run("sw io", 32'h00502023, 32'hFFFF_FC60, 1'b0, 3, 1'b1, -1, n);
        chk("sw io cycles", n, 6);
        chk("sw io io_write", n_iowr - b_iowr, 3);
        chk("sw io mem_write", n_mwr - b_mwr, 0);
        run("lw io ack1", 32'h00002283, 32'hFFFF_FC00, 1'b0, 1, 1'b0, -1, n);
        chk("lw io ack1 cycles", n, 5);
        snap(); run("lw io timeout", 32'h00002283, 32'hFFFF_FC00, 1'b0, 0, 1'b0, -1, n);
        chk("timeout cycles", n, 8);
        chk("timeout io_read", n_iord - b_iord, 4);
        chk("timeout bus_err", n_berr - b_berr, 1);
        chk("timeout reg_write", n_rw - b_rw, 0);

        snap(); run("beq taken", 32'h00000063, 32'h0, 1'b1, 0, 1'b0, -1, n);
        chk("beq cycles", n, 3);
        chk("beq taken tgt", n_tgt - b_tgt, 1);
        snap(); run("beq not", 32'h00000063, 32'h0, 1'b0, 0, 1'b0, -1, n);
        chk("beq not tgt", n_tgt - b_tgt, 0);
        run("bne", 32'h00001063, 32'h0, 1'b1, 0, 1'b0, -1, n);
        run("jal", 32'h000000EF, 32'h0, 1'b0, 0, 1'b0, -1, n);
        run("jalr", 32'h000100E7, 32'h0, 1'b0, 0, 1'b0, -1, n);

        snap(); run("illegal 7f", 32'h0000007F, 32'h0, 1'b0, 0, 1'b0, -1, n);
        chk("illegal cycles", n, 2);
        chk("illegal pulse", n_ill - b_ill, 1);
        run("lb", 32'h00000283, 32'h0, 1'b0, 0, 1'b0, -1, n);
        run("lui", 32'h000010B7, 32'h0, 1'b0, 0, 1'b0, -1, n);

        snap(); run("sw abort", 32'h00502023, 32'h0000_0040, 1'b0, 0, 1'b0, 3, n);
        run("add after rst", 32'h002081B3, 32'h0, 1'b0, 0, 1'b0, -1, n);
        chk("abort mem_write", n_mwr - b_mwr, 0);
        chk("abort reg_write", n_rw - b_rw, 1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
